// File: rtl/max1270_pkg.sv
// max1270_pkg: shared types for the MAX1270 scan scheduler.
// Holds the FSM state enum, control-byte field layout, START bit and PD code.
package max1270_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_NEXT
  } state_t;

  localparam int CMD_START  = 7;
  localparam int CMD_SEL_HI = 6;
  localparam int CMD_SEL_LO = 4;
  localparam int CMD_RNG    = 3;
  localparam int CMD_BIP    = 2;
  localparam int CMD_PD_HI  = 1;
  localparam int CMD_PD_LO  = 0;

  localparam logic       START_BIT = 1'b1;
  localparam logic [1:0] PD_NORMAL = 2'b00;

  function automatic logic [7:0] cmd_byte(
    input logic [2:0] ch,
    input logic       rng,
    input logic       bip
  );
    logic [7:0] b;
    b = '0;
    b[CMD_START]             = START_BIT;
    b[CMD_SEL_HI:CMD_SEL_LO] = ch;
    b[CMD_RNG]               = rng;
    b[CMD_BIP]               = bip;
    b[CMD_PD_HI:CMD_PD_LO]   = PD_NORMAL;
    return b;
  endfunction

endpackage

// File: rtl/max1270_prio_pick.sv
// max1270_prio_pick: lowest enabled channel at or above a pointer.
// Ports: i_mask channel enables, i_ptr start (8 = none left), o_found, o_ch.
module max1270_prio_pick (
  input  logic [7:0] i_mask,
  input  logic [3:0] i_ptr,
  output logic       o_found,
  output logic [2:0] o_ch
);

  // Scan downward so the last hit is the lowest qualifying channel.
  always_comb begin
    o_found = 1'b0;
    o_ch    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i_mask[i] && (4'(i) >= i_ptr)) begin
        o_found = 1'b1;
        o_ch    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/max1270_scan_sched.sv
// max1270_scan_sched: periodic / triggered MAX1270 channel scan scheduler.
// Ports: s_axil_clk/s_axil_rst (async active-low), i_run/i_trig start control,
//   i_ch_mask/i_rng_bip/i_period config, o_cmd_* control-byte handshake,
//   i_rsp_* phy result, o_smp_* result strobe, o_scan_done/o_busy/o_timeout.
// Optional response watchdog enabled by defining MAX1270_SCHED_TIMEOUT_EN.
module max1270_scan_sched
  import max1270_pkg::*;
#(
  parameter int PERIOD_W       = 24,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                s_axil_clk,
  input  logic                s_axil_rst,
  input  logic                i_run,
  input  logic                i_trig,
  input  logic [7:0]          i_ch_mask,
  input  logic [15:0]         i_rng_bip,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_cmd_valid,
  input  logic                i_cmd_ready,
  output logic [7:0]          o_cmd_byte,
  input  logic                i_rsp_valid,
  input  logic [11:0]         i_rsp_data,
  output logic                o_smp_valid,
  output logic [2:0]          o_smp_ch,
  output logic [11:0]         o_smp_data,
  output logic                o_scan_done,
  output logic                o_busy,
  output logic                o_timeout
);

  state_t              r_state;
  state_t              w_next;
  logic [PERIOD_W-1:0] r_per_cnt;
  logic [PERIOD_W-1:0] w_reload;
  logic [7:0]          r_mask;
  logic [15:0]         r_rng_bip;
  logic [3:0]          r_ptr;
  logic [2:0]          r_ch;
  logic                w_found;
  logic [2:0]          w_pick;
  logic                w_tick;
  logic                w_start;
  logic                w_to_hit;
  logic                w_issue;
  logic                r_smp_valid;
  logic [2:0]          r_smp_ch;
  logic [11:0]         r_smp_data;
  logic                r_done;

  assign w_tick   = (r_per_cnt == '0);
  assign w_reload = (i_period == '0) ? '0
                                     : i_period - PERIOD_W'(1);

  // Trigger wins in IDLE; once busy only the period tick restarts a scan.
  assign w_start =
    ((r_state == ST_IDLE) && (i_trig || (i_run && w_tick))) ||
    ((r_state == ST_WAIT_TICK) && i_run && w_tick);

  max1270_prio_pick u_pick (
    .i_mask  (r_mask),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_ch    (w_pick)
  );

`ifdef MAX1270_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  always_ff @(posedge s_axil_clk or negedge s_axil_rst) begin
    if (!s_axil_rst) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_WAIT_RSP) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // A response in the final cycle still wins over the watchdog.
  assign w_to_hit = (r_state == ST_WAIT_RSP) && !i_rsp_valid &&
                    (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge s_axil_clk or negedge s_axil_rst) begin
    if (!s_axil_rst) begin
      r_timeout <= 1'b0;
    end else if (w_start) begin
      r_timeout <= 1'b0;
    end else if (w_to_hit) begin
      r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_to_hit  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge s_axil_clk or negedge s_axil_rst) begin
    if (!s_axil_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start)    w_next = ST_NEXT;
        else if (i_run) w_next = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (w_start)     w_next = ST_NEXT;
        else if (!i_run) w_next = ST_IDLE;
      end
      ST_NEXT: begin
        w_next = w_found ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: begin
        if (i_cmd_ready) w_next = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (i_rsp_valid)   w_next = ST_NEXT;
        else if (w_to_hit) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Period counter parks at zero so a late tick stays pending.
  always_ff @(posedge s_axil_clk or negedge s_axil_rst) begin
    if (!s_axil_rst) begin
      r_per_cnt   <= '0;
      r_mask      <= '0;
      r_rng_bip   <= '0;
      r_ptr       <= '0;
      r_ch        <= '0;
      r_smp_valid <= 1'b0;
      r_smp_ch    <= '0;
      r_smp_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_smp_valid <= 1'b0;
      r_done      <= 1'b0;
      if (w_start) begin
        r_per_cnt <= w_reload;
        r_mask    <= i_ch_mask;
        r_rng_bip <= i_rng_bip;
        r_ptr     <= '0;
      end else if (!w_tick) begin
        r_per_cnt <= r_per_cnt - PERIOD_W'(1);
      end
      if (r_state == ST_NEXT) begin
        if (w_found) r_ch   <= w_pick;
        else         r_done <= 1'b1;
      end
      // Pointer reaching 8 after channel 7 leaves nothing to pick.
      if ((r_state == ST_WAIT_RSP) && i_rsp_valid) begin
        r_smp_valid <= 1'b1;
        r_smp_ch    <= r_ch;
        r_smp_data  <= i_rsp_data;
        r_ptr       <= {1'b0, r_ch} + 4'd1;
      end
    end
  end

  assign w_issue     = (r_state == ST_ISSUE);
  assign o_cmd_valid = w_issue;
  assign o_cmd_byte  = w_issue
    ? cmd_byte(r_ch, r_rng_bip[{r_ch, 1'b1}], r_rng_bip[{r_ch, 1'b0}])
    : 8'h00;
  assign o_smp_valid = r_smp_valid;
  assign o_smp_ch    = r_smp_ch;
  assign o_smp_data  = r_smp_data;
  assign o_scan_done = r_done;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_max1270_scan_sched.sv
// tb_max1270_scan_sched: directed self-checking bench for max1270_scan_sched.
// Builds with or without MAX1270_SCHED_TIMEOUT_EN (watchdog set to 16).
module tb_max1270_scan_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, trig;
  logic [7:0]  mask;
  logic [15:0] rb;
  logic [23:0] period;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_byte;
  logic        rsp_valid;
  logic [11:0] rsp_data;
  logic        smp_valid;
  logic [2:0]  smp_ch;
  logic [11:0] smp_data;
  logic        scan_done, busy, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  cmd_log [16];
  logic [2:0]  ch_log  [16];
  logic [11:0] dat_log [16];
  int          n_cmd, n_smp, n_done;
  int          starts [8];
  int          n_start;
  int          cnt;

  always #5 clk = ~clk;

  max1270_scan_sched #(
    .PERIOD_W       (24),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .s_axil_clk  (clk),
    .s_axil_rst  (rst_n),
    .i_run       (run),
    .i_trig      (trig),
    .i_ch_mask   (mask),
    .i_rng_bip   (rb),
    .i_period    (period),
    .o_cmd_valid (cmd_valid),
    .i_cmd_ready (cmd_ready),
    .o_cmd_byte  (cmd_byte),
    .i_rsp_valid (rsp_valid),
    .i_rsp_data  (rsp_data),
    .o_smp_valid (smp_valid),
    .o_smp_ch    (smp_ch),
    .o_smp_data  (smp_data),
    .o_scan_done (scan_done),
    .o_busy      (busy),
    .o_timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    n_cmd  = 0;
    n_smp  = 0;
    n_done = 0;
    for (int i = 0; i < 16; i++) begin
      cmd_log[i] = '0;
      ch_log[i]  = '0;
      dat_log[i] = '0;
    end
  endtask

  task automatic step_log();
    step();
    if (cmd_valid && cmd_ready && n_cmd < 16) begin
      cmd_log[n_cmd] = cmd_byte;
      n_cmd++;
    end
    if (smp_valid && n_smp < 16) begin
      ch_log[n_smp]  = smp_ch;
      dat_log[n_smp] = smp_data;
      n_smp++;
    end
    if (scan_done) n_done++;
  endtask

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    trig      = 1'b0;
    mask      = 8'h00;
    rb        = 16'h0000;
    period    = 24'd0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 12'h000;

    // Reset state
    step();
    step();
    chk("rst_outs", {cmd_valid, cmd_byte, smp_valid, smp_ch, smp_data,
                     scan_done, busy, timeout}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", {31'b0, busy}, 32'h0);

    // Mask A5, immediate ready/response
    mask      = 8'hA5;
    rb        = 16'h0000;
    cmd_ready = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 12'h5A3;
    clr_log();
    trig = 1'b1;
    step_log();
    trig = 1'b0;
    chk("a5_busy", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 40; i++) step_log();
    chk("a5_ncmd", n_cmd, 4);
    chk("a5_cmd0", {24'b0, cmd_log[0]}, 32'h80);
    chk("a5_cmd1", {24'b0, cmd_log[1]}, 32'hA0);
    chk("a5_cmd2", {24'b0, cmd_log[2]}, 32'hD0);
    chk("a5_cmd3", {24'b0, cmd_log[3]}, 32'hF0);
    chk("a5_nsmp", n_smp, 4);
    chk("a5_chs", {20'b0, ch_log[0], ch_log[1], ch_log[2], ch_log[3]},
        {20'b0, 3'd0, 3'd2, 3'd5, 3'd7});
    chk("a5_data", {20'b0, dat_log[0]}, 32'h5A3);
    chk("a5_done", n_done, 1);
    chk("a5_idle", {31'b0, busy}, 32'h0);

    // RNG/BIP encoding; config changed after start must not matter
    mask     = 8'h0A;
    rb       = 16'h0084;
    rsp_data = 12'h3C7;
    clr_log();
    trig = 1'b1;
    step_log();
    trig = 1'b0;
    mask = 8'h00;
    rb   = 16'hFFFF;
    for (int i = 0; i < 30; i++) step_log();
    chk("rb_ncmd", n_cmd, 2);
    chk("rb_cmd0", {24'b0, cmd_log[0]}, 32'h94);
    chk("rb_cmd1", {24'b0, cmd_log[1]}, 32'hB8);
    chk("rb_ch1", {29'b0, ch_log[1]}, 32'd3);
    chk("rb_data", {20'b0, dat_log[1]}, 32'h3C7);
    chk("rb_done", n_done, 1);

    // Empty mask: done two cycles after trigger, no command
    mask = 8'h00;
    clr_log();
    trig = 1'b1;
    step_log();
    trig = 1'b0;
    chk("m0_done_e1", {31'b0, scan_done}, 32'h0);
    chk("m0_busy_e1", {31'b0, busy}, 32'h1);
    step_log();
    chk("m0_done_e2", {31'b0, scan_done}, 32'h1);
    step_log();
    chk("m0_done_e3", {31'b0, scan_done}, 32'h0);
    chk("m0_ncmd", n_cmd, 0);
    chk("m0_busy", {31'b0, busy}, 32'h0);

    // Ready held low: command stable; stray response dropped
    mask      = 8'h01;
    rb        = 16'h0000;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = 12'hABC;
    clr_log();
    trig = 1'b1;
    step_log();
    trig = 1'b0;
    step_log();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (cmd_valid && cmd_byte == 8'h80) cnt++;
      rsp_valid = (k == 5);
      step_log();
    end
    rsp_valid = 1'b0;
    chk("hold_stable", cnt, 20);
    chk("hold_nosmp", n_smp, 0);
    cmd_ready = 1'b1;
    step_log();
    cmd_ready = 1'b0;
    chk("hs_valid_low", {31'b0, cmd_valid}, 32'h0);
    chk("hs_busy", {31'b0, busy}, 32'h1);
`ifdef MAX1270_SCHED_TIMEOUT_EN
    for (int k = 0; k < 15; k++) step_log();
    chk("to_pre", {30'b0, timeout, busy}, 32'h1);
    step_log();
    chk("to_hit", {30'b0, timeout, busy}, 32'h2);
    step_log();
    chk("to_sticky", {31'b0, timeout}, 32'h1);
    chk("to_nodone", n_done, 0);
    mask = 8'h00;
    trig = 1'b1;
    step_log();
    trig = 1'b0;
    chk("to_clear", {31'b0, timeout}, 32'h0);
    step_log();
    step_log();
`else
    for (int k = 0; k < 40; k++) step_log();
    chk("noto_wait", {30'b0, timeout, busy}, 32'h1);
    rsp_valid = 1'b1;
    step_log();
    rsp_valid = 1'b0;
    chk("late_smp", {16'b0, smp_valid, smp_ch, smp_data},
        {16'b0, 1'b1, 3'd0, 12'hABC});
    step_log();
    chk("late_done", {31'b0, scan_done}, 32'h1);
    step_log();
`endif

    // Reset during handshake drops cmd_valid at once
    mask = 8'h01;
    trig = 1'b1;
    step();
    trig = 1'b0;
    step();
    chk("r26_valid", {31'b0, cmd_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("r26_drop", {23'b0, cmd_valid, cmd_byte, busy}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Reset while waiting for response, then restart from channel 0
    mask      = 8'h24;
    cmd_ready = 1'b1;
    rsp_valid = 1'b0;
    trig      = 1'b1;
    step();
    trig = 1'b0;
    step();
    chk("r36_cmd", {24'b0, cmd_byte}, 32'hA0);
    step();
    chk("r36_wait", {31'b0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("r36_outs", {cmd_valid, cmd_byte, smp_valid, smp_ch, smp_data,
                     scan_done, busy, timeout}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    mask = 8'hFF;
    trig = 1'b1;
    step();
    trig = 1'b0;
    step();
    chk("r36_ch0", {23'b0, cmd_valid, cmd_byte}, 32'h180);
    rsp_valid = 1'b1;
    for (int k = 0; k < 40; k++) step();
    chk("r36_end", {31'b0, busy}, 32'h0);

    // Periodic run: starts exactly 100 cycles apart
    period    = 24'd100;
    mask      = 8'h01;
    cmd_ready = 1'b1;
    rsp_valid = 1'b1;
    run       = 1'b1;
    n_start   = 0;
    for (int c = 0; c < 400 && n_start < 4; c++) begin
      step();
      if (cmd_valid && cmd_ready) begin
        starts[n_start] = c;
        n_start++;
      end
    end
    chk("run_nstart", n_start, 4);
    chk("run_gap1", starts[1] - starts[0], 100);
    chk("run_gap2", starts[2] - starts[1], 100);
    chk("run_gap3", starts[3] - starts[2], 100);

    // Drop run mid-scan: current scan finishes, nothing more
    run = 1'b0;
    clr_log();
    for (int k = 0; k < 250; k++) step_log();
    chk("stop_done", n_done, 1);
    chk("stop_ncmd", n_cmd, 0);
    chk("stop_idle", {31'b0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
